// File: rtl/key_param_ctrl_pkg.sv
// Shared definitions for the key-driven camera parameter controller:
// key codes as delivered by the debounced key scanner, and the FSM state type.
package key_param_ctrl_pkg;

    // Active-low key codes on key_value[1:0] (bit0 = UP, bit1 = DOWN)
    localparam logic [1:0] KEY_NONE = 2'b11;
    localparam logic [1:0] KEY_UP   = 2'b10;
    localparam logic [1:0] KEY_DN   = 2'b01;
    localparam logic [1:0] KEY_BOTH = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/key_param_ctrl_cycle_timer.sv
// Loadable down-counter with terminal-count flag. Shared between the ack
// timeout and the post-transaction holdoff; the controller reloads it on each
// state change, so tc simply means "the loaded interval has elapsed".
module key_param_ctrl_cycle_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while enabled and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/key_param_ctrl.sv
// Key-driven parameter controller: turns debounced UP/DOWN/BOTH key events into
// a saturating parameter value and pushes every change to the SCCB writer over
// a req/ack handshake, with an ack timeout and a holdoff after each attempt.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  ST_IDLE | waiting for a key event; only state in which events are decoded
//  ST_REQ  | cfg_req high with candidate on cfg_data; waiting for ack/timeout
//  ST_HOLD | holdoff after commit or timeout; key events are dropped
module key_param_ctrl
    import key_param_ctrl_pkg::*;
#(
    parameter int unsigned           KEY_WIDTH   = 2,
    parameter int unsigned           VAL_WIDTH   = 8,
    parameter logic [VAL_WIDTH-1:0]  VAL_INIT    = 8'h40,
    parameter logic [VAL_WIDTH-1:0]  VAL_MIN     = 8'h00,
    parameter logic [VAL_WIDTH-1:0]  VAL_MAX     = 8'hFF,
    parameter logic [VAL_WIDTH-1:0]  STEP        = 8'h04,
    parameter int unsigned           ACK_TIMEOUT = 50000,
    parameter int unsigned           HOLDOFF     = 500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_flag,
    input  logic [KEY_WIDTH-1:0] key_value,
    output logic                 cfg_req,
    output logic [VAL_WIDTH-1:0] cfg_data,
    input  logic                 cfg_ack,
    output logic                 cfg_err,
    output logic                 busy,
    output logic [VAL_WIDTH-1:0] param_value
);

    localparam int unsigned TMR_MAX = (ACK_TIMEOUT > HOLDOFF) ? ACK_TIMEOUT : HOLDOFF;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF - 1);

    state_t               state;
    logic [VAL_WIDTH:0]   sum_ext;
    logic [VAL_WIDTH:0]   diff_ext;
    logic [VAL_WIDTH-1:0] up_val;
    logic [VAL_WIDTH-1:0] dn_val;
    logic [VAL_WIDTH-1:0] cand;
    logic                 ev_valid;
    logic                 start;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_en;
    logic                 tmr_tc;

    // Saturating step arithmetic one bit wider than the value, so neither the
    // carry out of UP nor the borrow out of DOWN can wrap into range
    always_comb begin
        sum_ext  = {1'b0, param_value} + {1'b0, STEP};
        diff_ext = {1'b0, param_value} - {1'b0, STEP};
        up_val   = (sum_ext > {1'b0, VAL_MAX}) ? VAL_MAX : sum_ext[VAL_WIDTH-1:0];
        // param < VAL_MIN + STEP covers both a borrow and landing below the floor
        if (diff_ext[VAL_WIDTH] ||
            ({1'b0, param_value} < ({1'b0, VAL_MIN} + {1'b0, STEP}))) begin
            dn_val = VAL_MIN;
        end else begin
            dn_val = diff_ext[VAL_WIDTH-1:0];
        end
    end

    // Key decode into a candidate value; KEY_NONE produces no event
    always_comb begin
        cand     = param_value;
        ev_valid = 1'b0;
        case (key_value[1:0])
            KEY_UP:   begin cand = up_val;   ev_valid = 1'b1; end
            KEY_DN:   begin cand = dn_val;   ev_valid = 1'b1; end
            KEY_BOTH: begin cand = VAL_INIT; ev_valid = 1'b1; end
            KEY_NONE: ev_valid = 1'b0;
            default:  ev_valid = 1'b0;
        endcase
    end

    assign start = key_flag && ev_valid && (cand != param_value);

    // Timer reload on each state entry: ack window into REQ, holdoff into HOLD
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: if (start) begin
                tmr_load = 1'b1;
                tmr_val  = ACK_LOAD;
            end
            ST_REQ: if (cfg_ack || tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = HOLD_LOAD;
            end
            default: tmr_load = 1'b0;
        endcase
    end

    assign tmr_en = (state != ST_IDLE);

    key_param_ctrl_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    // Controller FSM with all outputs registered; ack beats a same-cycle timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cfg_req     <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
            cfg_data    <= VAL_INIT;
            param_value <= VAL_INIT;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_REQ;
                        cfg_req  <= 1'b1;
                        cfg_data <= cand;
                        busy     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (cfg_ack) begin
                        param_value <= cfg_data;
                        cfg_req     <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (tmr_tc) begin
                        cfg_req <= 1'b0;
                        cfg_err <= 1'b1;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cfg_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_param_ctrl.sv
// Bench for key_param_ctrl: directed boundary walks plus randomized key events
// and ack delays, checked against a transaction-level model of the parameter.
module tb_key_param_ctrl;

    localparam int P_INIT = 'h40;
    localparam int P_MIN  = 'h00;
    localparam int P_MAX  = 'hFF;
    localparam int P_STEP = 4;
    localparam int P_TO   = 10;
    localparam int P_HOLD = 20;

    localparam logic [1:0] C_UP   = 2'b10;
    localparam logic [1:0] C_DN   = 2'b01;
    localparam logic [1:0] C_BOTH = 2'b00;
    localparam logic [1:0] C_NONE = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_flag;
    logic [1:0] key_value;
    logic       cfg_req;
    logic [7:0] cfg_data;
    logic       cfg_ack;
    logic       cfg_err;
    logic       busy;
    logic [7:0] param_value;

    int n_total = 0;
    int n_bad   = 0;
    int m_param = P_INIT;

    key_param_ctrl #(
        .KEY_WIDTH   (2),
        .VAL_WIDTH   (8),
        .VAL_INIT    (8'h40),
        .VAL_MIN     (8'h00),
        .VAL_MAX     (8'hFF),
        .STEP        (8'h04),
        .ACK_TIMEOUT (P_TO),
        .HOLDOFF     (P_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .cfg_req     (cfg_req),
        .cfg_data    (cfg_data),
        .cfg_ack     (cfg_ack),
        .cfg_err     (cfg_err),
        .busy        (busy),
        .param_value (param_value)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stray_key();
        if ($urandom_range(0, 3) == 0) begin
            key_flag  = 1'b1;
            key_value = 2'($urandom_range(0, 3));
        end else begin
            key_flag  = 1'b0;
            key_value = C_NONE;
        end
    endtask

    // One key event: ack_at = n acks in the n-th cycle cfg_req is seen high,
    // 0 or anything beyond the timeout window means the writer never answers
    task automatic do_event(input logic [1:0] code, input int ack_at);
        int  cand;
        bit  act;
        bit  exp_err;
        int  exp_hi;
        int  hi;
        int  hold;
        int  errs;
        act = 1'b1;
        case (code)
            C_UP:    cand = (m_param + P_STEP > P_MAX) ? P_MAX : m_param + P_STEP;
            C_DN:    cand = (m_param - P_STEP < P_MIN) ? P_MIN : m_param - P_STEP;
            C_BOTH:  cand = P_INIT;
            default: begin cand = m_param; act = 1'b0; end
        endcase
        if (cand == m_param) act = 1'b0;
        exp_err = (ack_at < 1) || (ack_at > P_TO);
        exp_hi  = exp_err ? P_TO : ack_at;

        key_flag  = 1'b1;
        key_value = code;
        step();
        key_flag  = 1'b0;
        key_value = C_NONE;
        chk("req_rise", int'(cfg_req), int'(act));
        chk("busy_rise", int'(busy), int'(act));

        if (!act) begin
            cfg_ack = 1'($urandom_range(0, 1));
            step();
            cfg_ack = 1'b0;
            chk("idle_req", int'(cfg_req), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_param", int'(param_value), m_param);
            return;
        end

        hi = 0;
        while (cfg_req === 1'b1 && hi < 30) begin
            hi++;
            chk("cfg_data", int'(cfg_data), cand);
            chk("req_err_low", int'(cfg_err), 0);
            cfg_ack = (hi == ack_at);
            stray_key();
            step();
        end
        cfg_ack = 1'b0;
        chk("req_len", hi, exp_hi);
        if (!exp_err) m_param = cand;
        chk("param_after", int'(param_value), m_param);

        hold = 0;
        errs = 0;
        while (busy === 1'b1 && hold < 40) begin
            if (cfg_err === 1'b1) errs++;
            chk("hold_req_low", int'(cfg_req), 0);
            hold++;
            stray_key();
            cfg_ack = 1'($urandom_range(0, 1));
            step();
        end
        key_flag  = 1'b0;
        key_value = C_NONE;
        cfg_ack   = 1'b0;
        chk("hold_len", hold, P_HOLD);
        chk("err_pulses", errs, int'(exp_err));
        chk("param_idle", int'(param_value), m_param);
        chk("req_idle", int'(cfg_req), 0);
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        key_flag  = 1'b0;
        key_value = C_NONE;
        cfg_ack   = 1'b0;
        repeat (3) step();
        chk("rst_req", int'(cfg_req), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(cfg_data), P_INIT);
        chk("rst_param", int'(param_value), P_INIT);
        rst_n = 1'b1;
        step();

        do_event(C_UP, 3);
        chk("first_up", int'(param_value), 'h44);

        guard = 0;
        while (m_param < 'hFC && guard < 100) begin
            do_event(C_UP, $urandom_range(1, P_TO));
            guard++;
        end
        do_event(C_UP, 2);
        chk("at_max", int'(param_value), 'hFF);
        do_event(C_UP, 1);
        chk("max_hold", int'(param_value), 'hFF);

        guard = 0;
        while (m_param > 3 && guard < 100) begin
            do_event(C_DN, $urandom_range(1, P_TO));
            guard++;
        end
        do_event(C_DN, 2);
        chk("at_min", int'(param_value), 'h00);
        do_event(C_DN, 1);
        chk("min_hold", int'(param_value), 'h00);
        do_event(C_BOTH, 4);
        chk("both_init", int'(param_value), 'h40);
        do_event(C_BOTH, 1);
        do_event(C_NONE, 1);

        do_event(C_UP, 0);
        chk("timeout_keep", int'(param_value), 'h40);
        do_event(C_UP, P_TO);
        chk("ack_at_timeout", int'(param_value), 'h44);
        do_event(C_UP, P_TO + 1);
        chk("late_ack_keep", int'(param_value), 'h44);

        for (int i = 0; i < 150; i++) begin
            do_event(2'($urandom_range(0, 3)),
                     ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, P_TO + 1));
        end

        do_event(C_BOTH, 1);
        key_flag  = 1'b1;
        key_value = C_UP;
        step();
        key_flag  = 1'b0;
        key_value = C_NONE;
        chk("rst_mid_req_up", int'(cfg_req), 1);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_req", int'(cfg_req), 0);
        chk("mid_rst_param", int'(param_value), P_INIT);
        chk("mid_rst_err", int'(cfg_err), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_data", int'(cfg_data), P_INIT);
        rst_n   = 1'b1;
        m_param = P_INIT;
        step();
        chk("post_rst_err", int'(cfg_err), 0);
        do_event(C_UP, 2);
        chk("post_rst_up", int'(param_value), 'h44);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
